// File: rtl/rec_play_ctrl.sv
//==============================================================================
// Module   : rec_play_ctrl
// Brief    : Record/playback sequencer splitting SRAM into equal slots, with
//            pause, loop-play and per-slot recorded length.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rec_play_ctrl #(
   parameter int ADDR_W    = 20,
   parameter int NUM_SLOTS = 4,
   parameter int SLOT_W    = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_stop,
   input  logic              i_rec_play,
   input  logic              i_loop,
   input  logic [SLOT_W-1:0] i_slot,
   input  logic              i_i2c_finished,
   input  logic [ADDR_W-1:0] i_rec_addr,
   input  logic [ADDR_W-1:0] i_play_addr,
   output logic              o_i2c_start,
   output logic              o_rec_start,
   output logic              o_rec_pause,
   output logic              o_rec_stop,
   output logic              o_play_start,
   output logic              o_play_pause,
   output logic              o_play_stop,
   output logic              o_play_rewind,
   output logic              o_play_en,
   output logic              o_sram_sel,
   output logic              o_sram_we_n,
   output logic [ADDR_W-1:0] o_base_addr,
   output logic [ADDR_W-1:0] o_last_addr,
   output logic              o_full,
   output logic              o_empty_err,
   output logic [2:0]        o_state
);

   localparam int OFF_W = ADDR_W - SLOT_W;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_INIT   = 3'd1;
   localparam logic [2:0] S_RECD   = 3'd2;
   localparam logic [2:0] S_RECD_P = 3'd3;
   localparam logic [2:0] S_PLAY   = 3'd4;
   localparam logic [2:0] S_PLAY_P = 3'd5;

   logic [2:0]        r_state, w_state_nxt;
   logic [SLOT_W-1:0] r_slot;
   logic [ADDR_W-1:0] r_len [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] r_valid;

   // Coincident key pulses resolve as stop > pause > start.
   logic w_stop, w_pause, w_start;
   assign w_stop  = i_stop;
   assign w_pause = i_pause & ~i_stop;
   assign w_start = i_start & ~i_pause & ~i_stop;

   logic [ADDR_W-1:0] w_sel_base, w_act_end;
   logic              w_sel_valid, w_rec_end, w_play_end;
   assign w_sel_base  = {i_slot, {OFF_W{1'b0}}};
   assign w_act_end   = {r_slot, {OFF_W{1'b1}}};
   assign w_sel_valid = r_valid[i_slot];
   assign w_rec_end   = (i_rec_addr == w_act_end);
   assign w_play_end  = (i_play_addr == o_last_addr);

   logic              w_rec_start, w_rec_pause, w_rec_stop;
   logic              w_play_start, w_play_pause, w_play_stop, w_play_rewind;
   logic              w_full, w_empty_err, w_latch_rec, w_latch_play, w_len_we;
   logic [ADDR_W-1:0] w_len_val;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_INIT;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_INIT:   if (i_i2c_finished) w_state_nxt = S_IDLE;
         S_IDLE: begin
            if (w_start && i_rec_play)       w_state_nxt = S_RECD;
            else if (w_start && w_sel_valid) w_state_nxt = S_PLAY;
         end
         S_RECD: begin
            if (w_stop || w_rec_end) w_state_nxt = S_IDLE;
            else if (w_pause)        w_state_nxt = S_RECD_P;
         end
         S_RECD_P: begin
            if (w_stop)       w_state_nxt = S_IDLE;
            else if (w_start) w_state_nxt = S_RECD;
         end
         S_PLAY: begin
            if (w_stop)                      w_state_nxt = S_IDLE;
            else if (w_pause)                w_state_nxt = S_PLAY_P;
            else if (w_play_end && !i_loop)  w_state_nxt = S_IDLE;
         end
         S_PLAY_P: begin
            if (w_stop)       w_state_nxt = S_IDLE;
            else if (w_start) w_state_nxt = S_PLAY;
         end
         default:  w_state_nxt = S_INIT;
      endcase
   end

   always_comb begin
      w_rec_start   = 1'b0;
      w_rec_pause   = 1'b0;
      w_rec_stop    = 1'b0;
      w_play_start  = 1'b0;
      w_play_pause  = 1'b0;
      w_play_stop   = 1'b0;
      w_play_rewind = 1'b0;
      w_full        = 1'b0;
      w_empty_err   = 1'b0;
      w_latch_rec   = 1'b0;
      w_latch_play  = 1'b0;
      w_len_we      = 1'b0;
      w_len_val     = i_rec_addr;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               if (i_rec_play) begin
                  w_rec_start = 1'b1;
                  w_latch_rec = 1'b1;
               end else if (w_sel_valid) begin
                  w_play_start = 1'b1;
                  w_latch_play = 1'b1;
               end else begin
                  w_empty_err = 1'b1;
               end
            end
         end
         S_RECD: begin
            if (w_stop) begin
               w_rec_stop = 1'b1;
               w_len_we   = 1'b1;
            end else if (w_rec_end) begin
               w_rec_stop = 1'b1;
               w_full     = 1'b1;
               w_len_we   = 1'b1;
               w_len_val  = w_act_end;
            end else if (w_pause) begin
               w_rec_pause = 1'b1;
            end
         end
         S_RECD_P: begin
            if (w_stop) begin
               w_rec_stop = 1'b1;
               w_len_we   = 1'b1;
            end else if (w_start) begin
               w_rec_start = 1'b1;
            end
         end
         S_PLAY: begin
            if (w_stop)          w_play_stop   = 1'b1;
            else if (w_pause)    w_play_pause  = 1'b1;
            else if (w_play_end) begin
               if (i_loop) w_play_rewind = 1'b1;
               else        w_play_stop   = 1'b1;
            end
         end
         S_PLAY_P: begin
            if (w_stop)       w_play_stop  = 1'b1;
            else if (w_start) w_play_start = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_i2c_start   <= 1'b1;
         o_rec_start   <= 1'b0;
         o_rec_pause   <= 1'b0;
         o_rec_stop    <= 1'b0;
         o_play_start  <= 1'b0;
         o_play_pause  <= 1'b0;
         o_play_stop   <= 1'b0;
         o_play_rewind <= 1'b0;
         o_full        <= 1'b0;
         o_empty_err   <= 1'b0;
         o_play_en     <= 1'b0;
         o_sram_sel    <= 1'b0;
         o_sram_we_n   <= 1'b1;
         o_base_addr   <= '0;
         o_last_addr   <= '0;
         r_slot        <= '0;
         r_valid       <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) r_len[i] <= '0;
      end else begin
         o_i2c_start   <= (w_state_nxt == S_INIT);
         o_rec_start   <= w_rec_start;
         o_rec_pause   <= w_rec_pause;
         o_rec_stop    <= w_rec_stop;
         o_play_start  <= w_play_start;
         o_play_pause  <= w_play_pause;
         o_play_stop   <= w_play_stop;
         o_play_rewind <= w_play_rewind;
         o_full        <= w_full;
         o_empty_err   <= w_empty_err;
         // Level outputs follow the state being entered so they align with o_state.
         o_play_en     <= (w_state_nxt == S_PLAY);
         o_sram_sel    <= (w_state_nxt == S_RECD) || (w_state_nxt == S_RECD_P);
         o_sram_we_n   <= (w_state_nxt != S_RECD);
         if (w_latch_rec || w_latch_play) begin
            r_slot      <= i_slot;
            o_base_addr <= w_sel_base;
         end
         if (w_latch_play) o_last_addr <= r_len[i_slot];
         if (w_len_we) begin
            r_len[r_slot]   <= w_len_val;
            r_valid[r_slot] <= 1'b1;
            o_last_addr     <= w_len_val;
         end
      end
   end

   assign o_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_rec_play_ctrl.sv
//==============================================================================
// Module   : tb_rec_play_ctrl
// Brief    : Directed self-checking bench for rec_play_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rec_play_ctrl;

   localparam int ADDR_W = 20;
   localparam int SLOT_W = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0, pause = 1'b0, stop = 1'b0;
   logic              rec_play = 1'b0, loop = 1'b0, i2c_fin = 1'b0;
   logic [SLOT_W-1:0] slot = '0;
   logic [ADDR_W-1:0] rec_addr = '0, play_addr = '0;

   logic              i2c_start, rec_start, rec_pause, rec_stop;
   logic              play_start, play_pause, play_stop, play_rewind;
   logic              play_en, sram_sel, sram_we_n, full, empty_err;
   logic [ADDR_W-1:0] base_addr, last_addr;
   logic [2:0]        state;

   int n_tests = 0;
   int n_fail  = 0;

   rec_play_ctrl #(.ADDR_W(ADDR_W), .NUM_SLOTS(4), .SLOT_W(SLOT_W)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
      .i_rec_play(rec_play), .i_loop(loop), .i_slot(slot),
      .i_i2c_finished(i2c_fin), .i_rec_addr(rec_addr), .i_play_addr(play_addr),
      .o_i2c_start(i2c_start), .o_rec_start(rec_start), .o_rec_pause(rec_pause),
      .o_rec_stop(rec_stop), .o_play_start(play_start), .o_play_pause(play_pause),
      .o_play_stop(play_stop), .o_play_rewind(play_rewind), .o_play_en(play_en),
      .o_sram_sel(sram_sel), .o_sram_we_n(sram_we_n), .o_base_addr(base_addr),
      .o_last_addr(last_addr), .o_full(full), .o_empty_err(empty_err),
      .o_state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset and I2C init gating
      repeat (2) tick();
      check("rst_state", state, 1);
      check("rst_we_n", sram_we_n, 1);
      check("rst_play_en", play_en, 0);
      check("rst_base", base_addr, 0);
      rst = 1'b0;
      repeat (50) tick();
      check("init_state", state, 1);
      check("init_i2c", i2c_start, 1);
      start = 1'b1; rec_play = 1'b1;
      tick();
      start = 1'b0;
      check("init_ignore_start", state, 1);
      i2c_fin = 1'b1;
      tick();
      check("idle_state", state, 0);
      check("idle_i2c", i2c_start, 0);

      // Record slot 2, stop mid-region
      slot = 2'd2; rec_play = 1'b1; rec_addr = 20'h80000;
      start = 1'b1; tick(); start = 1'b0;
      check("rec2_start", rec_start, 1);
      check("rec2_state", state, 2);
      check("rec2_sel", sram_sel, 1);
      check("rec2_we_n", sram_we_n, 0);
      check("rec2_base", base_addr, 20'h80000);
      tick();
      check("rec2_start_1cyc", rec_start, 0);
      rec_addr = 20'h80123;
      stop = 1'b1; tick(); stop = 1'b0;
      check("rec2_stop", rec_stop, 1);
      check("rec2_idle", state, 0);
      check("rec2_we_n_off", sram_we_n, 1);
      tick();
      check("rec2_stop_1cyc", rec_stop, 0);

      // Play slot 2
      rec_play = 1'b0; play_addr = '0;
      start = 1'b1; tick(); start = 1'b0;
      check("play2_start", play_start, 1);
      check("play2_state", state, 4);
      check("play2_base", base_addr, 20'h80000);
      check("play2_last", last_addr, 20'h80123);
      check("play2_en", play_en, 1);
      check("play2_sel", sram_sel, 0);
      stop = 1'b1; tick(); stop = 1'b0;
      check("play2_stop", play_stop, 1);
      check("play2_idle", state, 0);

      // Play an empty slot
      slot = 2'd1;
      start = 1'b1; tick(); start = 1'b0;
      check("empty_err", empty_err, 1);
      check("empty_state", state, 0);
      check("empty_play_en", play_en, 0);
      tick();
      check("empty_err_1cyc", empty_err, 0);

      // Record slot 3 to the region end
      slot = 2'd3; rec_play = 1'b1; rec_addr = 20'hC0000;
      start = 1'b1; tick(); start = 1'b0;
      check("rec3_state", state, 2);
      rec_addr = 20'hFFFFF;
      tick();
      check("rec3_full", full, 1);
      check("rec3_stop", rec_stop, 1);
      check("rec3_idle", state, 0);
      rec_addr = '0;
      tick();
      check("rec3_full_1cyc", full, 0);

      // Loop and non-loop end of playback on slot 3
      rec_play = 1'b0; play_addr = '0;
      start = 1'b1; tick(); start = 1'b0;
      check("play3_last", last_addr, 20'hFFFFF);
      check("play3_base", base_addr, 20'hC0000);
      loop = 1'b1; play_addr = 20'hFFFFF;
      tick();
      play_addr = '0;
      check("loop_rewind", play_rewind, 1);
      check("loop_state", state, 4);
      check("loop_no_stop", play_stop, 0);
      tick();
      check("loop_rewind_1cyc", play_rewind, 0);
      loop = 1'b0; play_addr = 20'hFFFFF;
      tick();
      play_addr = '0;
      check("end_stop", play_stop, 1);
      check("end_idle", state, 0);
      check("end_rewind", play_rewind, 0);

      // Pause/resume recording on slot 0, then pause+stop together
      slot = 2'd0; rec_play = 1'b1; rec_addr = 20'h00010;
      start = 1'b1; tick(); start = 1'b0;
      check("rec0_we_n", sram_we_n, 0);
      pause = 1'b1; tick(); pause = 1'b0;
      check("rec0_pause", rec_pause, 1);
      check("rec0_paused", state, 3);
      check("rec0_we_n_p", sram_we_n, 1);
      check("rec0_sel_p", sram_sel, 1);
      start = 1'b1; tick(); start = 1'b0;
      check("rec0_resume", rec_start, 1);
      check("rec0_resumed", state, 2);
      check("rec0_we_n_r", sram_we_n, 0);
      pause = 1'b1; stop = 1'b1; tick(); pause = 1'b0; stop = 1'b0;
      check("prio_stop", rec_stop, 1);
      check("prio_no_pause", rec_pause, 0);
      check("prio_idle", state, 0);
      rec_play = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      check("play0_last", last_addr, 20'h00010);
      check("play0_base", base_addr, 20'h00000);
      pause = 1'b1; tick(); pause = 1'b0;
      check("play0_pause", play_pause, 1);
      check("play0_paused", state, 5);
      check("play0_en_p", play_en, 0);
      start = 1'b1; tick(); start = 1'b0;
      check("play0_resume", play_start, 1);
      check("play0_en_r", play_en, 1);

      // Reset mid-playback drops everything, no stop pulse, slots cleared
      rst = 1'b1; tick(); rst = 1'b0;
      check("mid_rst_state", state, 1);
      check("mid_rst_no_stop", play_stop, 0);
      check("mid_rst_play_en", play_en, 0);
      check("mid_rst_last", last_addr, 0);
      tick();
      slot = 2'd2;
      start = 1'b1; tick(); start = 1'b0;
      check("cleared_empty", empty_err, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
